// File: rtl/tick_sequencer.sv
// Run/stop sequencer around a programmable-period tick prescaler: one-cycle Tick, toggling SlowClk, optional burst.
// Optional build macro TICK_SEQ_PAUSE_EN adds a Pause input that freezes counting while running.
module tick_sequencer #(
    parameter int               WIDTH     = 21,
    parameter logic [WIDTH-1:0] DEFAULT_N = 21'd1666667,
    parameter int               BURST_W   = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               Stop,
    input  logic               LoadN,
    input  logic [WIDTH-1:0]   NewN,
    input  logic [BURST_W-1:0] BurstLen,
`ifdef TICK_SEQ_PAUSE_EN
    input  logic               Pause,
`endif
    output logic               Tick,
    output logic               SlowClk,
    output logic               Busy,
    output logic               Done,
    output logic [BURST_W-1:0] TickCount
);

    // state  | meaning
    // S_IDLE | period may be loaded, waiting for Start
    // S_RUN  | prescaler counting, ticks emitted
    // S_DONE | burst finished, Done high for one cycle
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   n_reg, n_nxt;
    logic [WIDTH-1:0]   cnt, cnt_nxt;
    logic [BURST_W-1:0] len_reg, len_nxt;
    logic [BURST_W-1:0] tick_count, tc_nxt;
    logic               tick, tick_nxt;
    logic               slow_clk, slow_nxt;
    logic               paused;
    logic               terminal;

`ifdef TICK_SEQ_PAUSE_EN
    assign paused = Pause;
`else
    assign paused = 1'b0;
`endif

    assign terminal = (cnt == n_reg - WIDTH'(1));

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= S_IDLE;
            n_reg      <= DEFAULT_N;
            cnt        <= '0;
            len_reg    <= '0;
            tick_count <= '0;
            tick       <= 1'b0;
            slow_clk   <= 1'b0;
        end else begin
            state      <= state_nxt;
            n_reg      <= n_nxt;
            cnt        <= cnt_nxt;
            len_reg    <= len_nxt;
            tick_count <= tc_nxt;
            tick       <= tick_nxt;
            slow_clk   <= slow_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n_reg;
        cnt_nxt   = cnt;
        len_nxt   = len_reg;
        tc_nxt    = tick_count;
        tick_nxt  = 1'b0;
        slow_nxt  = slow_clk;
        case (state)
            S_IDLE: begin
                // Periods below 2 are clamped so the terminal compare never sees a zero period
                if (LoadN)
                    n_nxt = (NewN < WIDTH'(2)) ? WIDTH'(2) : NewN;
                if (Start) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = '0;
                    tc_nxt    = '0;
                    len_nxt   = BurstLen;
                end
            end
            S_RUN: begin
                if (Stop) begin
                    state_nxt = S_IDLE;
                end else if (!paused) begin
                    if (terminal) begin
                        cnt_nxt  = '0;
                        tick_nxt = 1'b1;
                        slow_nxt = ~slow_clk;
                        tc_nxt   = tick_count + BURST_W'(1);
                        if (len_reg != '0 && tc_nxt == len_reg)
                            state_nxt = S_DONE;
                    end else begin
                        cnt_nxt = cnt + WIDTH'(1);
                    end
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Tick      = tick;
    assign SlowClk   = slow_clk;
    assign Busy      = (state != S_IDLE);
    assign Done      = (state == S_DONE);
    assign TickCount = tick_count;

endmodule
